sram_access_controller: RTL
===========================

// Module: sram_access_controller
// PURPOSE
// - Sequences LDR/STR accesses from the MEM stage onto a 16-bit asynchronous SRAM; each 32-bit word = two half-word phases.
// - Driven by the mem_r_en / mem_w_en decoded in ID and carried down the pipeline.
// - ready low stalls (freezes) all pipeline registers while an access is in flight.
// PARAMETERS
// - ADDR_W       18    SRAM half-word address width
// - BASE_ADDR    1024  byte address mapped to SRAM word 0
// - WAIT_CYCLES  3     cycles per half-word phase; legal range >=1
// PORTS
// - clk          in   1       single clock, rising edge
// - rst          in   1       synchronous, active-low reset (rst==0 resets on clk edge)
// - rd_en        in   1       load request (MEM stage mem_r_en)
// - wr_en        in   1       store request (MEM stage mem_w_en)
// - address      in   32      byte address from ALU result
// - write_data   in   32      store data (Rm value)
// - read_data    out  32      load result, registered
// - ready        out  1       1 = no access pending / access completes this cycle
// - sram_addr    out  ADDR_W  half-word address
// - sram_dq_o    out  16      write data to SRAM
// - sram_dq_i    in   16      read data from SRAM
// - sram_dq_oe   out  1       1 = drive sram_dq_o onto the bus
// - sram_we_n / sram_oe_n / sram_ce_n  out 1 each, active-low strobes
// - sram_ub_n / sram_lb_n  out 1 each, tied 0 (full half-word always)
// BEHAVIOUR
// - States: IDLE, LOW, HIGH, DONE. Phase counter 0..WAIT_CYCLES-1.
// - IDLE: if rd_en|wr_en -> LOW; latch address, write_data, op (read if rd_en, write otherwise; rd_en+wr_en both high = read, write dropped).
// - LOW: counter increments each cycle; on counter==WAIT_CYCLES-1 -> HIGH, counter=0; read captures sram_dq_i as lo half on that cycle.
// - HIGH: same counting; read captures hi half on last cycle; -> DONE.
// - DONE: one cycle; read_data={hi,lo} valid; -> IDLE unconditionally (request still high here belongs to the same instruction, never restarted).
// - ready = (IDLE & ~rd_en & ~wr_en) | DONE. Combinational from state and inputs.
// - Latency: request first seen in IDLE at cycle 0 -> ready=1 at cycle 2*WAIT_CYCLES+1; ready low cycles 0..2*WAIT_CYCLES.
// - Address: word = (addr_q - BASE_ADDR) >> 2, 32-bit subtract, truncated; sram_addr = {word[ADDR_W-2:0], phase} with phase 0=LOW,1=HIGH. Out-of-range / below BASE_ADDR wraps modulo 2^ADDR_W, no error flag. addr_q[1:0] ignored.
// - Strobes decoded from registered state/op only: sram_ce_n=0 in LOW/HIGH; sram_oe_n=0 in LOW/HIGH of reads; sram_we_n=0 and sram_dq_oe=1 in LOW/HIGH of writes; sram_dq_o = LOW ? wdata_q[15:0] : wdata_q[31:16]. All strobes inactive in IDLE/DONE.
// - read_data holds last completed load; unchanged by writes.
// - Reset (also mid-access): state=IDLE, counter=0, read_data=0, latched regs=0, we_n/oe_n/ce_n=1, dq_oe=0, sram_addr=0; in-flight access abandoned, no partial write completion guaranteed.
// STRUCTURE
// - Shared package arm_pkg: sram_state_t enum {IDLE,LOW,HIGH,DONE}, SRAM_BASE_ADDR, SRAM_ADDR_W constants.
// - One sub-module: sram_phase_counter (param MAX=WAIT_CYCLES; inputs clk,rst,clr,en; output last).
// - Top: FSM, request latches, read assembly register, strobe decode.
// TESTING
// - Reset: hold rst=0 3 cycles mid-read -> state IDLE, read_data=0, ready=1 (no request), all strobes 1, dq_oe=0.
// - Read @0x400, SRAM[0]=0x5678, SRAM[1]=0x1234, W=3 -> ready low 7 cycles, high cycle 7, read_data=0x12345678.
// - Write 0xDEADBEEF @0x408 -> sram_addr 4 with 0xBEEF for 3 cycles we_n=0, then addr 5 with 0xDEAD; ready at cycle 7.
// - Back-to-back: LDR then STR, request held through DONE -> second access starts in IDLE after DONE, no duplicate access.
// - W=1 build: read -> ready at cycle 3; rd_en=wr_en=1 -> read only, we_n stays 1.
// - Address 0x3FC (below base) -> word wraps to sram_addr {ADDR_W-1{1},0}=0x3FFFE; no hang.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared types and constants for the SRAM access path
package arm_pkg;

  // Access sequencer states: one cycle to accept, two half-word phases, one completion cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  // Byte address that maps onto SRAM word 0
  localparam int SRAM_BASE_ADDR = 1024;

  // SRAM half-word address width
  localparam int SRAM_ADDR_W = 18;

endpackage

// File: rtl/sram_access_controller_if.sv
// rtl/sram_access_controller_if.sv - pipeline request and SRAM pin bundle
interface sram_access_controller_if #(
  parameter int ADDR_W = 18
);

  // Pipeline side
  logic              rd_en;
  logic              wr_en;
  logic [31:0]       address;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              ready;

  // SRAM side
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_o;
  logic [15:0]       sram_dq_i;
  logic              sram_dq_oe;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic              sram_ce_n;
  logic              sram_ub_n;
  logic              sram_lb_n;

  // Pipeline plus SRAM device view: drives requests and read data, observes the controller
  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_i,
    input  read_data, ready, sram_addr, sram_dq_o, sram_dq_oe,
    input  sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
  );

  // Controller view
  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_i,
    output read_data, ready, sram_addr, sram_dq_o, sram_dq_oe,
    output sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
  );

endinterface

// File: rtl/sram_access_controller_phase_counter.sv
// rtl/sram_access_controller_phase_counter.sv - wait-state counter for one half-word phase
module sram_phase_counter #(
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = (MAX > 1) ? $clog2(MAX) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last = (cnt_q == CW'(MAX - 1));

  // Count 0..MAX-1 while enabled, wrapping so the next phase starts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_access_controller.sv
// rtl/sram_access_controller.sv - sequences 32-bit loads/stores as two 16-bit SRAM phases
module sram_access_controller
  import arm_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int BASE_ADDR   = SRAM_BASE_ADDR,
  parameter int WAIT_CYCLES = 3
) (
  input logic                      clk,
  input logic                      rst,
  sram_access_controller_if.slave  bus
);

  sram_state_t       state_q;
  sram_state_t       state_d;
  logic              op_read_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [15:0]       lo_q;
  logic [31:0]       read_data_q;

  logic              req;
  logic              cnt_en;
  logic              cnt_clr;
  logic              cnt_last;
  logic              phase_hi;
  logic              active;
  logic [ADDR_W-2:0] word;

  assign req      = bus.rd_en | bus.wr_en;
  assign phase_hi = (state_q == HIGH);
  assign active   = (state_q == LOW) || (state_q == HIGH);

  // Word offset from the SRAM base; out-of-window addresses simply wrap
  assign word = (ADDR_W-1)'((addr_q - 32'(BASE_ADDR)) >> 2);

  sram_phase_counter #(
    .MAX (WAIT_CYCLES)
  ) u_phase_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

  // Next-state logic; DONE always returns to IDLE so a held request is not replayed
  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = LOW;
      end
      LOW: begin
        cnt_en  = 1'b1;
        cnt_clr = 1'b0;
        if (cnt_last) state_d = HIGH;
      end
      HIGH: begin
        cnt_en  = 1'b1;
        cnt_clr = 1'b0;
        if (cnt_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latches and read assembly
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_read_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      read_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        op_read_q <= bus.rd_en;
        addr_q    <= bus.address;
        wdata_q   <= bus.write_data;
      end
      if (state_q == LOW && cnt_last && op_read_q) begin
        lo_q <= bus.sram_dq_i;
      end
      if (state_q == HIGH && cnt_last && op_read_q) begin
        read_data_q <= {bus.sram_dq_i, lo_q};
      end
    end
  end

  // SRAM strobes and bus decoded from registered state only
  always_comb begin
    bus.sram_ce_n  = 1'b1;
    bus.sram_oe_n  = 1'b1;
    bus.sram_we_n  = 1'b1;
    bus.sram_dq_oe = 1'b0;
    bus.sram_dq_o  = '0;
    bus.sram_addr  = '0;
    if (active) begin
      bus.sram_ce_n  = 1'b0;
      bus.sram_oe_n  = ~op_read_q;
      bus.sram_we_n  = op_read_q;
      bus.sram_dq_oe = ~op_read_q;
      bus.sram_dq_o  = phase_hi ? wdata_q[31:16] : wdata_q[15:0];
      bus.sram_addr  = {word, phase_hi};
    end
  end

  assign bus.ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign bus.read_data = read_data_q;
  assign bus.sram_ub_n = 1'b0;
  assign bus.sram_lb_n = 1'b0;

endmodule
